// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_pkg
// Description : Shared types and constants for the elastic pipeline-stage
//               buffer. It defines the stage state encoding, the IF/ID payload
//               layout and the NOP instruction used as a bubble payload.
// Revision    : 1.0 - initial release
// ============================================================================
package pipe_pkg;

    // Stage occupancy state. The value 2'd3 is unused.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } pipe_state_e;

    // IF/ID payload. DATA_W of the IF/ID stage is the width of this struct.
    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pc_plus4;
    } if_id_payload_t;

    localparam int IF_ID_W = $bits(if_id_payload_t);

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    // Number of entries held in each state.
    function automatic logic [1:0] occupancy_of(input pipe_state_e s);
        logic [1:0] n;
        case (s)
            ST_ONE:  n = 2'd1;
            ST_FULL: n = 2'd2;
            default: n = 2'd0;
        endcase
        return n;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_stage_buf_sat_counter.sv
`default_nettype none
// ============================================================================
// Module      : sat_counter
// Description : Saturating up-counter. It holds at all-ones and never wraps.
//               Clear has priority over increment.
// Ports       : i_clk   - clock, rising edge
//               i_clr   - synchronous active-high clear to zero
//               i_inc   - increment enable
//               o_count - current count
// Revision    : 1.0 - initial release
// ============================================================================
module sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_clr,
    input  logic             i_inc,
    output logic [WIDTH-1:0] o_count
);

    logic [WIDTH-1:0] w_cnt_d;
    logic [WIDTH-1:0] r_cnt_q;

    always_comb begin
        w_cnt_d = r_cnt_q;
        if (i_clr) begin
            w_cnt_d = '0;
        end else if (i_inc && (r_cnt_q != {WIDTH{1'b1}})) begin
            w_cnt_d = r_cnt_q + {{(WIDTH-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge i_clk) begin
        r_cnt_q <= w_cnt_d;
    end

    assign o_count = r_cnt_q;

endmodule
`default_nettype wire

// File: rtl/pipe_stage_buf.sv
`default_nettype none
// ============================================================================
// Module      : pipe_stage_buf
// Description : Elastic pipeline-stage register with a valid/ready handshake
//               and a 2-entry skid buffer (main + skid). o_up_ready is
//               registered, so downstream stalls never ripple combinationally
//               upstream. Supports flush-to-bubble and occupancy reporting.
//               Optional stall/flush performance counters are enabled by
//               defining the macro PIPE_STAGE_CNT_EN. Without that macro the
//               counter ports are tied to zero.
// Ports       : i_clk, i_rst       - clock, synchronous active-high reset
//               i_flush            - drop all held and incoming data
//               i_up_valid/o_up_ready/i_up_data - upstream handshake
//               o_dn_valid/i_dn_ready/o_dn_data - downstream handshake
//               o_occupancy        - entries held (0..2)
//               o_stall_cnt        - cycles with o_dn_valid && !i_dn_ready
//               o_flush_cnt        - flush cycles
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_stage_buf
    import pipe_pkg::*;
#(
    parameter int                DATA_W     = IF_ID_W,
    parameter logic [DATA_W-1:0] BUBBLE_VAL = '0
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_flush,
    input  logic              i_up_valid,
    output logic              o_up_ready,
    input  logic [DATA_W-1:0] i_up_data,
    output logic              o_dn_valid,
    input  logic              i_dn_ready,
    output logic [DATA_W-1:0] o_dn_data,
    output logic [1:0]        o_occupancy,
    output logic [31:0]       o_stall_cnt,
    output logic [31:0]       o_flush_cnt
);

    pipe_state_e       r_state_q, w_state_d;
    logic [DATA_W-1:0] r_main_q,  w_main_d;
    logic [DATA_W-1:0] r_skid_q,  w_skid_d;
    logic              r_up_ready_q;
    logic              r_dn_valid_q;
    logic [1:0]        r_occ_q;

    logic w_accept;
    logic w_take;

    assign w_accept = i_up_valid && r_up_ready_q;
    assign w_take   = r_dn_valid_q && i_dn_ready;

    always_comb begin
        w_state_d = r_state_q;
        w_main_d  = r_main_q;
        w_skid_d  = r_skid_q;
        if (i_flush) begin
            // A same-cycle accept is dropped here; a same-cycle take has
            // already completed on the downstream side.
            w_state_d = ST_EMPTY;
            w_main_d  = BUBBLE_VAL;
            w_skid_d  = BUBBLE_VAL;
        end else begin
            case (r_state_q)
                ST_EMPTY: begin
                    if (w_accept) begin
                        w_main_d  = i_up_data;
                        w_state_d = ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (w_accept && w_take) begin
                        w_main_d  = i_up_data;
                    end else if (w_accept) begin
                        w_skid_d  = i_up_data;
                        w_state_d = ST_FULL;
                    end else if (w_take) begin
                        w_main_d  = BUBBLE_VAL;
                        w_state_d = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (w_take) begin
                        w_main_d  = r_skid_q;
                        w_skid_d  = BUBBLE_VAL;
                        w_state_d = ST_ONE;
                    end
                end
                default: begin
                    w_state_d = ST_EMPTY;
                    w_main_d  = BUBBLE_VAL;
                    w_skid_d  = BUBBLE_VAL;
                end
            endcase
        end
    end

    // Handshake outputs are derived from the next state and registered, so
    // they depend on stored state only.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state_q    <= ST_EMPTY;
            r_main_q     <= BUBBLE_VAL;
            r_skid_q     <= BUBBLE_VAL;
            r_up_ready_q <= 1'b1;
            r_dn_valid_q <= 1'b0;
            r_occ_q      <= 2'd0;
        end else begin
            r_state_q    <= w_state_d;
            r_main_q     <= w_main_d;
            r_skid_q     <= w_skid_d;
            r_up_ready_q <= (w_state_d != ST_FULL);
            r_dn_valid_q <= (w_state_d != ST_EMPTY);
            r_occ_q      <= occupancy_of(w_state_d);
        end
    end

    assign o_up_ready  = r_up_ready_q;
    assign o_dn_valid  = r_dn_valid_q;
    assign o_dn_data   = r_main_q;
    assign o_occupancy = r_occ_q;

`ifdef PIPE_STAGE_CNT_EN
    // Counters clear on reset only; flush does not clear them.
    sat_counter #(.WIDTH(32)) u_stall_cnt (
        .i_clk   (i_clk),
        .i_clr   (i_rst),
        .i_inc   (r_dn_valid_q && !i_dn_ready),
        .o_count (o_stall_cnt)
    );

    sat_counter #(.WIDTH(32)) u_flush_cnt (
        .i_clk   (i_clk),
        .i_clr   (i_rst),
        .i_inc   (i_flush),
        .o_count (o_flush_cnt)
    );
`else
    assign o_stall_cnt = 32'd0;
    assign o_flush_cnt = 32'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_buf.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_stage_buf
// Description : Self-checking bench for pipe_stage_buf. A queue-based
//               reference model (at most two entries, FIFO order) predicts
//               the handshake, data, occupancy and counters.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_stage_buf;
    import pipe_pkg::*;

    localparam int            DW     = IF_ID_W;
    localparam logic [DW-1:0] BUBBLE = {NOP_INSTR, 64'h0};
    typedef logic [DW-1:0] data_t;

    logic        clk = 1'b0;
    logic        rst, flush, up_valid, dn_ready;
    data_t       up_data;
    logic        up_ready, dn_valid;
    data_t       dn_data;
    logic [1:0]  occ;
    logic [31:0] stall_cnt, flush_cnt;

    // Stand-alone narrow counter so saturation is reachable quickly.
    logic       sc_clr, sc_inc;
    logic [3:0] sc_cnt;

    int n_pass  = 0;
    int n_total = 0;

    data_t   q[$];
    longint  m_stall, m_flush;

    always #5 clk = ~clk;

    pipe_stage_buf #(.DATA_W(DW), .BUBBLE_VAL(BUBBLE)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_flush     (flush),
        .i_up_valid  (up_valid),
        .o_up_ready  (up_ready),
        .i_up_data   (up_data),
        .o_dn_valid  (dn_valid),
        .i_dn_ready  (dn_ready),
        .o_dn_data   (dn_data),
        .o_occupancy (occ),
        .o_stall_cnt (stall_cnt),
        .o_flush_cnt (flush_cnt)
    );

    sat_counter #(.WIDTH(4)) u_sc (
        .i_clk   (clk),
        .i_clr   (sc_clr),
        .i_inc   (sc_inc),
        .o_count (sc_cnt)
    );

    function automatic logic [31:0] exp_cnt(input longint v);
`ifdef PIPE_STAGE_CNT_EN
        return (v > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : v[31:0];
`else
        return (v >= 0) ? 32'd0 : 32'd0;
`endif
    endfunction

    // Apply one cycle of inputs, advance the model across the rising edge,
    // and return at the following falling edge.
    task automatic drive(input logic r, input logic f, input logic uv,
                         input data_t ud, input logic dr);
        logic acc, tk;
        rst = r; flush = f; up_valid = uv; up_data = ud; dn_ready = dr;
        if (r) begin
            q.delete();
            m_stall = 0;
            m_flush = 0;
        end else begin
            acc = uv && (q.size() < 2);
            tk  = (q.size() > 0) && dr;
            if ((q.size() > 0) && !dr) m_stall++;
            if (f) begin
                m_flush++;
                q.delete();
            end else begin
                if (tk)  void'(q.pop_front());
                if (acc) q.push_back(ud);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 1'b0, 1'b1, data_t'(8'hAA), 1'b1);
            n_total++;
            if (dn_valid !== 1'b0 || occ !== 2'd0 || dn_data !== BUBBLE)
                $display("FAIL reset_state: valid=%0b occ=%0d data=%h, required valid=0 occ=0 data=%h",
                         dn_valid, occ, dn_data, BUBBLE);
            else n_pass++;
        end
        drive(1'b0, 1'b0, 1'b0, '0, 1'b1);
        n_total++;
        if (up_ready !== 1'b1 || dn_valid !== 1'b0 || stall_cnt !== 32'd0 || flush_cnt !== 32'd0)
            $display("FAIL reset_release: up_ready=%0b valid=%0b stall=%0d flush=%0d, required 1 0 0 0",
                     up_ready, dn_valid, stall_cnt, flush_cnt);
        else n_pass++;
    endtask

    task automatic test_stream();
        for (int i = 1; i <= 3; i++) begin
            drive(1'b0, 1'b0, 1'b1, data_t'(i), 1'b1);
            n_total++;
            if (dn_valid !== 1'b1 || dn_data !== data_t'(i) || occ !== 2'd1 || up_ready !== 1'b1)
                $display("FAIL stream_%0d: valid=%0b data=%h occ=%0d rdy=%0b, required 1 %h 1 1",
                         i, dn_valid, dn_data, occ, up_ready, data_t'(i));
            else n_pass++;
        end
        drive(1'b0, 1'b0, 1'b0, '0, 1'b1);
        n_total++;
        if (dn_valid !== 1'b0 || occ !== 2'd0 || dn_data !== BUBBLE)
            $display("FAIL stream_drain: valid=%0b occ=%0d data=%h, required 0 0 %h",
                     dn_valid, occ, dn_data, BUBBLE);
        else n_pass++;
    endtask

    task automatic test_backpressure();
        data_t seen[$];
        drive(1'b0, 1'b0, 1'b1, data_t'(8'h10), 1'b1);
        drive(1'b0, 1'b0, 1'b1, data_t'(8'h11), 1'b0);
        drive(1'b0, 1'b0, 1'b1, data_t'(8'h12), 1'b0);
        n_total++;
        if (occ !== 2'd2 || up_ready !== 1'b0 || dn_data !== data_t'(8'h10))
            $display("FAIL bp_full: occ=%0d rdy=%0b data=%h, required 2 0 %h",
                     occ, up_ready, dn_data, data_t'(8'h10));
        else n_pass++;
        // 0x12 was refused and is re-presented until accepted.
        seen.push_back(dn_data);
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b0, (i < 2), data_t'(8'h12), 1'b1);
            if (dn_valid) seen.push_back(dn_data);
        end
        n_total++;
        if (seen.size() !== 3 || seen[0] !== data_t'(8'h10) || seen[1] !== data_t'(8'h11)
            || seen[2] !== data_t'(8'h12))
            $display("FAIL bp_order: got %0d items first=%h, required 3 items 10,11,12",
                     seen.size(), (seen.size() > 0) ? seen[0] : '0);
        else n_pass++;
    endtask

    task automatic test_flush_full();
        drive(1'b0, 1'b0, 1'b1, data_t'(8'h20), 1'b0);
        drive(1'b0, 1'b0, 1'b1, data_t'(8'h21), 1'b0);
        n_total++;
        if (occ !== 2'd2)
            $display("FAIL flush_prefill: occ=%0d, required 2", occ);
        else n_pass++;
        drive(1'b0, 1'b1, 1'b1, data_t'(8'h55), 1'b0);
        n_total++;
        if (occ !== 2'd0 || dn_valid !== 1'b0 || dn_data !== BUBBLE || up_ready !== 1'b1)
            $display("FAIL flush_full: occ=%0d valid=%0b data=%h rdy=%0b, required 0 0 %h 1",
                     occ, dn_valid, dn_data, up_ready, BUBBLE);
        else n_pass++;
        drive(1'b0, 1'b0, 1'b0, '0, 1'b1);
        n_total++;
        if (dn_valid !== 1'b0 || dn_data === data_t'(8'h55))
            $display("FAIL flush_no_leak: valid=%0b data=%h, required valid=0", dn_valid, dn_data);
        else n_pass++;
    endtask

    task automatic test_counters();
        drive(1'b1, 1'b0, 1'b0, '0, 1'b0);
        drive(1'b0, 1'b0, 1'b1, data_t'(8'h30), 1'b0);
        for (int i = 0; i < 5; i++) drive(1'b0, 1'b0, 1'b0, '0, 1'b0);
        drive(1'b0, 1'b1, 1'b0, '0, 1'b1);
        drive(1'b0, 1'b1, 1'b0, '0, 1'b1);
        n_total++;
        if (stall_cnt !== exp_cnt(m_stall) || flush_cnt !== exp_cnt(m_flush)
`ifdef PIPE_STAGE_CNT_EN
            || stall_cnt !== 32'd5 || flush_cnt !== 32'd2
`endif
           )
            $display("FAIL counters: stall=%0d flush=%0d, required %0d %0d",
                     stall_cnt, flush_cnt, exp_cnt(m_stall), exp_cnt(m_flush));
        else n_pass++;
        // Saturation on the narrow counter: 20 increments saturate at 15.
        sc_clr = 1'b1; sc_inc = 1'b0;
        @(negedge clk);
        sc_clr = 1'b0; sc_inc = 1'b1;
        for (int i = 0; i < 20; i++) @(negedge clk);
        n_total++;
        if (sc_cnt !== 4'hF)
            $display("FAIL sat_hold: count=%h, required F", sc_cnt);
        else n_pass++;
        sc_clr = 1'b1;
        @(negedge clk);
        sc_clr = 1'b0; sc_inc = 1'b0;
        n_total++;
        if (sc_cnt !== 4'h0)
            $display("FAIL sat_clear: count=%h, required 0", sc_cnt);
        else n_pass++;
    endtask

    task automatic test_random();
        int errs;
        data_t exp_d;
        errs = 0;
        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(0, 99) == 0), ($urandom_range(0, 19) == 0),
                  ($urandom_range(0, 3) != 0), {$urandom, $urandom, $urandom},
                  ($urandom_range(0, 2) != 0));
            exp_d = (q.size() > 0) ? q[0] : BUBBLE;
            n_total++;
            if (dn_valid !== (q.size() > 0) || up_ready !== (q.size() < 2)
                || occ !== 2'(q.size()) || dn_data !== exp_d
                || stall_cnt !== exp_cnt(m_stall) || flush_cnt !== exp_cnt(m_flush)) begin
                if (errs < 10)
                    $display("FAIL random_cyc%0d: valid=%0b rdy=%0b occ=%0d data=%h stall=%0d flush=%0d, required %0b %0b %0d %h %0d %0d",
                             i, dn_valid, up_ready, occ, dn_data, stall_cnt, flush_cnt,
                             (q.size() > 0), (q.size() < 2), q.size(), exp_d,
                             exp_cnt(m_stall), exp_cnt(m_flush));
                errs++;
            end else n_pass++;
        end
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; up_valid = 1'b0; up_data = '0; dn_ready = 1'b0;
        sc_clr = 1'b1; sc_inc = 1'b0;
        m_stall = 0; m_flush = 0;
        @(negedge clk);
        test_reset();
        test_stream();
        test_backpressure();
        test_flush_full();
        test_counters();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pipe_stage_buf.md
# pipe_stage_buf

Parametrised elastic pipeline-stage register for the pipelined RV32 core, generalising the fixed IF/ID register. It replaces per-stage stall/flush wiring with a valid/ready handshake and a 2-entry skid buffer, so upstream stalls are registered rather than combinational. It also provides flush-to-bubble, occupancy reporting and optional performance counters. It is instantiated between any two stages (IF/ID, ID/EX, ...) with a stage-specific payload width.

## Interface
- DATA_W, 96: payload width in bits (IF/ID: instr + PC + PC+4).
- BUBBLE_VAL, '0: payload value presented downstream when empty or after flush (NOP encoding is legal).
- i_clk  in  1  clock, rising edge.
- i_rst  in  1  reset; synchronous, active-high.
- i_flush  in  1  synchronous flush: discard all held and incoming data.
- i_up_valid  in  1  upstream payload valid.
- o_up_ready  out  1  stage can accept; registered (function of state only).
- i_up_data  in  DATA_W  upstream payload.
- o_dn_valid  out  1  downstream payload valid.
- i_dn_ready  in  1  downstream accepts (0 = stall).
- o_dn_data  out  DATA_W  downstream payload.
- o_occupancy  out  2  entries held: 0, 1 or 2.
- o_stall_cnt  out  32  cycles with o_dn_valid && !i_dn_ready (macro-dependent).
- o_flush_cnt  out  32  number of flush cycles (macro-dependent).

## Operation
- Two payload registers: main (drives o_dn_data) and skid. States ST_EMPTY, ST_ONE, ST_FULL.
- Definitions: accept = i_up_valid && o_up_ready; take = o_dn_valid && i_dn_ready.
- o_up_ready = (state != ST_FULL); o_dn_valid = (state != ST_EMPTY); o_occupancy = 0/1/2 per state.
- ST_EMPTY: accept -> main <= i_up_data, ST_ONE; else hold. i_dn_ready ignored.
- ST_ONE:
  - accept && take -> main <= i_up_data, stay ST_ONE.
  - accept && !take -> skid <= i_up_data, ST_FULL.
  - !accept && take -> main <= BUBBLE_VAL, ST_EMPTY.
  - neither -> hold.
- ST_FULL: take -> main <= skid, skid <= BUBBLE_VAL, ST_ONE; else hold. No accept is possible.
- Ordering is strict FIFO; no payload is ever duplicated or dropped except by flush.
- Priority per edge: i_rst > i_flush > handshake.
- i_flush: state <= ST_EMPTY, main and skid <= BUBBLE_VAL. An upstream accept in the same cycle is discarded. A take in the same cycle counts as completed for downstream; upstream sees the handshake complete but the data is dropped.
- Stall is expressed only via i_dn_ready; there is no separate stall input.

## Timing
- Reset (i_rst high at an edge): state ST_EMPTY, main = skid = BUBBLE_VAL, o_dn_valid=0, o_occupancy=0, counters 0. o_up_ready=1 from the first edge after reset. Inputs are ignored while i_rst is high. Reset mid-operation discards all held data.
- Latency: accepted payload appears on o_dn_data/o_dn_valid one cycle after the accept edge.
- Throughput: 1 payload/cycle while i_dn_ready=1.
- Backpressure: after i_dn_ready falls, one further upstream payload is absorbed (skid). o_up_ready falls the cycle after the FULL transition and rises the cycle after the first take in ST_FULL.
- o_dn_data is stable while o_dn_valid && !i_dn_ready.
- Counters saturate at 32'hFFFF_FFFF and never wrap. Flush cycles are counted even when the stage is empty.

## Configuration
- PIPE_STAGE_CNT_EN defined: o_stall_cnt and o_flush_cnt are live saturating counters, reset to 0 by i_rst only (not by flush).
- Not defined: counter logic is removed and both ports are tied to 32'd0. All other behaviour is identical.

## Structure
- Package pipe_pkg:
  - typedef enum logic [1:0] pipe_state_e {ST_EMPTY, ST_ONE, ST_FULL}.
  - Payload struct typedef if_id_payload_t {instr, pc, pc_plus4}, so DATA_W = $bits(if_id_payload_t).
  - Constant NOP_INSTR = 32'h0000_0013.
- One sub-module, sat_counter (parametrised width, synchronous active-high clear, increment enable), instantiated twice under PIPE_STAGE_CNT_EN.

## Test plan
- Reset: hold i_rst 2 cycles with i_up_valid=1, data 0xAA -> o_dn_valid=0, o_occupancy=0, o_dn_data=BUBBLE_VAL; o_up_ready=1 after release.
- Streaming: i_dn_ready=1, push 0x1,0x2,0x3 back-to-back -> o_dn_data shows 0x1,0x2,0x3 on consecutive cycles, one cycle delayed; occupancy stays 1.
- Backpressure: stream 0x10,0x11,0x12 with i_dn_ready=0 from cycle 1 -> occupancy 2, o_up_ready=0, 0x12 not accepted. Raise i_dn_ready -> 0x10, 0x11, 0x12 delivered in order, none lost.
- Flush while full: occupancy 2, assert i_flush with i_up_valid=1, data 0x55 -> next cycle occupancy 0, o_dn_valid=0, o_dn_data=BUBBLE_VAL, 0x55 never emitted.
- Counters (PIPE_STAGE_CNT_EN): 5 stalled cycles plus 2 flush cycles -> o_stall_cnt=5, o_flush_cnt=2. Preload near max -> counter holds 0xFFFF_FFFF.
- Macro off: the same stimulus gives identical handshake and data traces, with counter ports at 0.
